// File: rtl/layer3_maxpool2x2.sv
// -----------------------------------------------------------------------------
// layer3_maxpool2x2
//   Streaming 2x2 / stride-2 max-pool over a raster-order IEEE-754 binary32
//   pixel stream. Only a half-width line buffer is kept: even rows fold each
//   horizontal pair into lb[], and odd rows fold their pair with the stored
//   value to emit one pooled pixel.
//
// Parameters
//   DATA_WIDTH    pixel width (binary32 bit pattern)
//   IMAGE_WIDTH   input pixels per line, even and >= 2
//   IMAGE_HEIGHT  input lines per frame, even and >= 2
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   valid_in   input pixel strobe
//   pxl_in     input pixel, sampled when valid_in = 1
//   pxl_out    pooled pixel, holds between strobes
//   valid_out  one-cycle strobe per pooled pixel
//
// Build option
//   MAXPOOL_RELU_EN  when defined, any pooled result with the sign bit set
//                    (including -0) is output as +0.
// -----------------------------------------------------------------------------
module layer3_maxpool2x2 #(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 32,
    parameter int IMAGE_HEIGHT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out
);

    localparam int CW  = (IMAGE_WIDTH  > 2) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int RW  = (IMAGE_HEIGHT > 2) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int LBN = IMAGE_WIDTH / 2;
    localparam int LBA = (LBN > 1) ? $clog2(LBN) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);

    generate
        if ((IMAGE_WIDTH % 2) != 0 || IMAGE_WIDTH < 2 ||
            (IMAGE_HEIGHT % 2) != 0 || IMAGE_HEIGHT < 2) begin : g_bad_dims
            $error("layer3_maxpool2x2: IMAGE_WIDTH/IMAGE_HEIGHT must be even and >= 2");
        end
    endgenerate

    // Maps a float bit pattern onto an unsigned key with the same ordering:
    // negatives are bit-inverted, positives get the sign bit set.
    function automatic logic [DATA_WIDTH-1:0] fkey(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ~x : (x ^ {1'b1, {(DATA_WIDTH-1){1'b0}}});
    endfunction

    // a arrived before b; strict compare keeps a on ties.
    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (fkey(b) > fkey(a)) ? b : a;
    endfunction

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] h_q, h_d;
    logic [DATA_WIDTH-1:0] pxl_q, pxl_d;
    logic                  vld_q, vld_d;

    logic [DATA_WIDTH-1:0] lb_q [LBN];
    logic [LBA-1:0]        lb_addr;
    logic                  lb_we;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] win_max;
    logic [DATA_WIDTH-1:0] win_out;

    // Same address for read and write, so the odd-row read and even-row
    // write of a column pair never collide.
    assign lb_addr  = LBA'(col_q >> 1);
    // Horizontal pair max is shared by the line-buffer write and the output.
    assign pair_max = fmax(h_q, pxl_in);
    assign win_max  = fmax(lb_q[lb_addr], pair_max);

`ifdef MAXPOOL_RELU_EN
    assign win_out = win_max[DATA_WIDTH-1] ? '0 : win_max;
`else
    assign win_out = win_max;
`endif

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        h_d   = h_q;
        pxl_d = pxl_q;
        vld_d = 1'b0;
        lb_we = 1'b0;
        if (valid_in) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (!col_q[0]) begin
                h_d = pxl_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                pxl_d = win_out;
                vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
            h_q   <= '0;
            pxl_q <= '0;
            vld_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            h_q   <= h_d;
            pxl_q <= pxl_d;
            vld_q <= vld_d;
        end
    end

    // Line buffer is always written on an even row before the odd row reads
    // it, so it carries no reset.
    always_ff @(posedge clk) begin
        if (lb_we) lb_q[lb_addr] <= pair_max;
    end

    assign pxl_out   = pxl_q;
    assign valid_out = vld_q;

endmodule

// File: tb/tb_layer3_maxpool2x2.sv
module tb_layer3_maxpool2x2;
    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] pxl_in;
    logic [31:0] pxl_out;
    logic        valid_out;

    layer3_maxpool2x2 #(.DATA_WIDTH(32), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .pxl_in    (pxl_in),
        .pxl_out   (pxl_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] frame [H][W];
    int          drow, dcol;
    logic [31:0] exp_q [$];
    int          exp_t [$];

    function automatic logic [31:0] fkey(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    // Pool one window, visiting pixels in arrival order; strict > keeps the
    // earliest on ties.
    function automatic logic [31:0] pool(input int r, input int c);
        logic [31:0] a [4];
        logic [31:0] best;
        a[0] = frame[r][c];   a[1] = frame[r][c+1];
        a[2] = frame[r+1][c]; a[3] = frame[r+1][c+1];
        best = a[0];
        for (int i = 1; i < 4; i++) if (fkey(a[i]) > fkey(best)) best = a[i];
`ifdef MAXPOOL_RELU_EN
        if (best[31]) best = 32'h0;
`endif
        return best;
    endfunction

    // Exact binary32 encoding of a small non-negative integer.
    function automatic logic [31:0] itof(input int i);
        int e;
        if (i == 0) return 32'h0;
        e = $clog2(i + 1) - 1;
        return (32'(127 + e) << 23) | ((32'(i) << (23 - e)) & 32'h007F_FFFF);
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [31:0] p, input int gap);
        valid_in = 1'b1;
        pxl_in   = p;
        frame[drow][dcol] = p;
        if ((drow % 2 == 1) && (dcol % 2 == 1)) begin
            exp_q.push_back(pool(drow - 1, dcol - 1));
            exp_t.push_back(cyc + 1);
        end
        if (dcol == W - 1) begin
            dcol = 0;
            drow = (drow == H - 1) ? 0 : drow + 1;
        end else begin
            dcol++;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [31:0] px [W*H], input int maxgap);
        for (int i = 0; i < W*H; i++) send(px[i], (maxgap > 0) ? $urandom_range(maxgap, 0) : 0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
        repeat (2) begin @(posedge clk); #1; end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("rst_pxl_out", pxl_out, 32'h0);
            chk("rst_valid_out", {31'b0, valid_out}, 32'h0);
        end else if (valid_out) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid_out", {31'b0, valid_out}, 32'h0);
            end else begin
                chk("pxl_out", pxl_out, exp_q.pop_front());
                chk("strobe_cycle", 32'(cyc), 32'(exp_t.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] f [W*H];
    logic [31:0] pool_vals [6];

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        pxl_in   = '0;
        drow     = 0;
        dcol     = 0;
        pool_vals = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000,
                      32'h8000_0000, 32'h4100_0000, 32'hC100_0000};
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Ramp 0..15, back-to-back
        for (int i = 0; i < W*H; i++) f[i] = itof(i);
        send_frame(f, 0);
        drain("ramp_drain");

        // Same ramp with random idle gaps
        send_frame(f, 3);
        drain("ramp_gap_drain");

        // All -1.0 except (1,0) = -0.5
        for (int i = 0; i < W*H; i++) f[i] = 32'hBF80_0000;
        f[1*W + 0] = 32'hBF00_0000;
        send_frame(f, 1);
        drain("neg_drain");

        // Signed zeros and ties
        for (int i = 0; i < W*H; i++) f[i] = $urandom;
        f[0] = 32'h8000_0000; f[1] = 32'h0000_0000;
        f[W] = 32'h8000_0000; f[W+1] = 32'h8000_0000;
        f[2] = 32'h3F80_0000; f[3] = 32'h3F80_0000;
        f[W+2] = 32'h3F80_0000; f[W+3] = 32'h3F80_0000;
        f[2*W] = 32'h0000_0000; f[2*W+1] = 32'h8000_0000;
        f[3*W] = 32'h8000_0000; f[3*W+1] = 32'h8000_0000;
        send_frame(f, 0);
        drain("zero_tie_drain");

        // Random frames streamed without gaps between frames
        for (int fr = 0; fr < 4; fr++) begin
            for (int i = 0; i < W*H; i++)
                f[i] = ($urandom_range(1, 0) == 1) ? pool_vals[$urandom_range(5, 0)] : 32'($urandom);
            send_frame(f, (fr % 2 == 0) ? 0 : 3);
        end
        drain("rand_drain");

        // Reset in the middle of a frame
        for (int i = 0; i < 6; i++) send(itof(i + 20), 0);
        drain("pre_reset_drain");
        reset = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        drow = 0;
        dcol = 0;
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < W*H; i++) f[i] = itof(i);
        send_frame(f, 0);
        drain("post_reset_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/layer3_maxpool2x2.md
# layer3_maxpool2x2

Streaming 2×2, stride-2 max-pooling stage that consumes the raster-order IEEE-754 single-precision pixel stream produced by the layer3 residual stack (`valid_out`/`pxl_out`). It emits the pooled feature map at (IMAGE_WIDTH/2)×(IMAGE_HEIGHT/2) in raster order. It uses a half-width line buffer, so no frame storage is needed. It sits directly downstream of layer3 on the reduced-resolution path and feeds the next stage with the same valid-strobe stream protocol.

## Interface
- `DATA_WIDTH`, 32: pixel width; IEEE-754 binary32 bit pattern.
- `IMAGE_WIDTH`, 32: input pixels per line; must be even and ≥2. Odd values are an elaboration error.
- `IMAGE_HEIGHT`, 32: input lines per frame; must be even and ≥2. Odd values are an elaboration error.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  input pixel strobe; one pixel per cycle when high.
- `pxl_in`  in  DATA_WIDTH  input pixel in raster order; sampled only when `valid_in`=1.
- `pxl_out`  out  DATA_WIDTH  pooled pixel; holds its last value between strobes.
- `valid_out`  out  1  one-cycle strobe per pooled pixel.

## Operation
- Counters:
  - `col` runs 0..IMAGE_WIDTH-1 and `row` runs 0..IMAGE_HEIGHT-1. Both advance only on `valid_in`.
  - `col` wraps to 0 and increments `row`. `row` wraps to 0 at end of frame.
  - Consecutive frames stream with no gap or restart.
- Compare key:
  - key(x) = x[31] ? ~x : (x ^ 32'h8000_0000). The maximum is the operand with the larger unsigned key.
  - This gives a total order in which -0 < +0. NaNs are not expected and are ordered by key with no special handling.
  - On ties, the earlier-arriving operand is kept, so the result is bit-identical to it.
- Even `row`:
  - Even `col`: latch the pixel into the hold register `h`.
  - Odd `col`: write max(h, pxl_in) to `lb[col>>1]`. `lb` has IMAGE_WIDTH/2 entries of DATA_WIDTH.
- Odd `row`:
  - Even `col`: latch the pixel into `h`.
  - Odd `col`: register m = max(lb[col>>1], h, pxl_in) into `pxl_out` and assert `valid_out` for one cycle.
- Output count: exactly (IMAGE_WIDTH/2)·(IMAGE_HEIGHT/2) strobes per frame, in raster order of the pooled map.
- Line buffer: may be registers or inferred RAM. Read address = write address = `col>>1`, so there is no read/write conflict within a cycle.
- Reset (any time, including mid-frame):
  - `col`, `row`, `h`, `pxl_out` clear to 0 and `valid_out` clears to 0.
  - `lb` contents need not clear; they are always written before they are read.
  - The next `valid_in` after reset deassertion is treated as pixel (0,0).

## Timing
- Latency: `valid_out` rises on the clock edge that samples the pixel at odd `row`/odd `col`, i.e. 1 cycle after that `valid_in` cycle.
- Throughput: `valid_in` may be high every cycle or have arbitrary gaps. There is no backpressure and no ready signal. `valid_out` never exceeds 1 strobe per 2 input strobes.
- `valid_out` is high for exactly one cycle per pooled pixel, even when `valid_in` stays high.
- Reset values: `pxl_out`=0, `valid_out`=0.
- No output is produced during even rows. The last strobe of a frame follows the last input pixel by 1 cycle. The first pixel of the next frame may arrive in that same cycle with no interaction.

## Configuration
- `MAXPOOL_RELU_EN`:
  - Defined: fused ReLU on the output. If the pooled result has bit 31 set (including -0), `pxl_out` is forced to 32'h0000_0000; positive values pass unchanged. Latency is unchanged.
  - Undefined: raw max is output bit-exact, and negatives pass through.

## Test plan
- W=H=4, back-to-back `valid_in`, pixels = float(0..15) raster order -> `pxl_out` sequence 0x40A00000, 0x40E00000, 0x41500000, 0x41700000; 4 strobes, each 1 cycle after input pixels 5, 7, 13, 15.
- Same frame with random 0–3 idle cycles between pixels -> identical values and count; each strobe 1 cycle after its triggering input.
- All pixels -1.0 (0xBF800000) except pixel (1,0) = -0.5 (0xBF000000) -> first output 0xBF000000, others 0xBF800000.
- Same stimulus as the previous scenario with `MAXPOOL_RELU_EN` defined -> all four outputs 0x00000000.
- Window containing only -0 (0x80000000) and +0 -> output 0x00000000. Window of equal 0x3F800000 -> 0x3F800000.
- Assert `reset` low after 6 pixels of frame 1, release, then send a full 4×4 frame -> no strobe during or after reset until the new frame. Outputs match the first scenario and `pxl_out` reads 0 while held in reset.
